mrd_ctrl_fsm: RTL

- Sequencing controller for the mixed-radix DFT memory top.
- Captures the DFT size at input SOP and factors it into a radix-4/2/3/5 stage list.
- Steps the memory through the phases sink (2'b00), butterfly read (2'b01), butterfly write (2'b10) and source kick (2'b11), one read/write pair per stage.
- Consumes the memory's status strobes and drives its state, stage index and per-stage radix.

---
 rtl/mrd_ctrl_fsm.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mrd_ctrl_fsm.sv
// mrd_ctrl_fsm -- sequencing controller for the mixed-radix DFT memory.
//
// Captures the DFT size at sink_sop and factors it, one factor per clock,
// into a radix-4/2/3/5 stage list. It then walks the memory through sink,
// one butterfly read/write pair per stage, and a one-cycle source kick.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   sink_sop        input frame start pulse; sink_dftpts valid with it
//   sink_ongoing    memory busy storing the input frame
//   rd_ongoing      memory butterfly-read burst active
//   wr_ongoing      memory butterfly-write burst active
//   source_ongoing  memory output burst active
//   state           phase to memory: 00 sink, 01 read, 10 write, 11 source kick
//   dftpts          captured DFT size
//   current_stage   active stage index
//   Nf              packed radix per stage, entry k at [3k+2:3k]
//   num_stages      number of valid stages
//   err_factor      pulse: size not factorable or below 2
//   err_timeout     pulse: no write burst within WR_TIMEOUT cycles
//   overrun         pulse: sink_sop seen outside SINK
module mrd_ctrl_fsm #(
    parameter int MAX_STAGES = 6,
    parameter int WR_TIMEOUT = 4095
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sink_sop,
    input  logic [11:0]             sink_dftpts,
    input  logic                    sink_ongoing,
    input  logic                    rd_ongoing,
    input  logic                    wr_ongoing,
    input  logic                    source_ongoing,
    output logic [1:0]              state,
    output logic [11:0]             dftpts,
    output logic [2:0]              current_stage,
    output logic [3*MAX_STAGES-1:0] Nf,
    output logic [2:0]              num_stages,
    output logic                    err_factor,
    output logic                    err_timeout,
    output logic                    overrun
);

    localparam int          NFW  = 3 * MAX_STAGES;
    localparam int          CW   = $clog2(WR_TIMEOUT + 1);
    localparam logic [2:0]  MAXS = 3'(MAX_STAGES);

    // SRC_WAIT drives 00 like SINK but is a distinct state.
    typedef enum logic [2:0] {S_SINK, S_RD, S_WR, S_SRC, S_SRCW} fsm_e;

    fsm_e            fsm_q, fsm_d;
    logic            prev_q, prev_d;       // registered level of the watched strobe
    logic            fell_q, fell_d;       // sink_ongoing fall latched in SINK
    logic            seen_q, seen_d;       // SOP accepted in this SINK visit
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [11:0]     r_q, r_d;             // factoring residual
    logic            busy_q, busy_d;
    logic            ok_q, ok_d;
    logic [NFW-1:0]  nf_q, nf_d;
    logic [2:0]      nstg_q, nstg_d;
    logic [2:0]      stage_q, stage_d;
    logic [11:0]     dft_q, dft_d;
    logic [1:0]      state_q, state_d;
    logic            errf_q, errf_d;
    logic            errt_q, errt_d;
    logic            ovr_q, ovr_d;

    logic            watch, fall, entering, wr_to;
    logic [2:0]      fac;
    logic [11:0]     r_div;
    logic            step_ok, step_fail, fdone;

    function automatic logic [1:0] enc(fsm_e s);
        case (s)
            S_RD:    enc = 2'b01;
            S_WR:    enc = 2'b10;
            S_SRC:   enc = 2'b11;
            default: enc = 2'b00;
        endcase
    endfunction

    // Strobe watched in the current state. prev_q is cleared on every state
    // entry, so a level already high at entry counts as a rise and a level
    // already low at entry is never a fall.
    always_comb begin
        watch = 1'b0;
        case (fsm_q)
            S_SINK:  watch = sink_ongoing;
            S_RD:    watch = rd_ongoing;
            S_WR:    watch = wr_ongoing;
            S_SRCW:  watch = source_ongoing;
            default: watch = 1'b0;
        endcase
    end

    assign fall  = prev_q & ~watch;
    // prev_q low with the strobe still low in WR means no rise since entry.
    assign wr_to = (fsm_q == S_WR) && !prev_q && !watch &&
                   (cnt_q == CW'(WR_TIMEOUT - 1));

    // Factor selection, highest priority first.
    always_comb begin
        fac   = 3'd0;
        r_div = r_q;
        if (r_q[1:0] == 2'b00) begin
            fac   = 3'd4;
            r_div = r_q >> 2;
        end else if (!r_q[0]) begin
            fac   = 3'd2;
            r_div = r_q >> 1;
        end else if (r_q % 12'd3 == 12'd0) begin
            fac   = 3'd3;
            r_div = r_q / 12'd3;
        end else if (r_q % 12'd5 == 12'd0) begin
            fac   = 3'd5;
            r_div = r_q / 12'd5;
        end
    end

    assign fdone     = busy_q && (r_q == 12'd1);
    assign step_fail = busy_q && (r_q != 12'd1) && ((fac == 3'd0) || (nstg_q == MAXS));
    assign step_ok   = busy_q && (r_q != 12'd1) && (fac != 3'd0) && (nstg_q != MAXS);

    // State register and all output/datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= S_SINK;
            prev_q  <= 1'b0;
            fell_q  <= 1'b0;
            seen_q  <= 1'b0;
            cnt_q   <= '0;
            r_q     <= '0;
            busy_q  <= 1'b0;
            ok_q    <= 1'b0;
            nf_q    <= '0;
            nstg_q  <= '0;
            stage_q <= '0;
            dft_q   <= '0;
            state_q <= '0;
            errf_q  <= 1'b0;
            errt_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            prev_q  <= prev_d;
            fell_q  <= fell_d;
            seen_q  <= seen_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            busy_q  <= busy_d;
            ok_q    <= ok_d;
            nf_q    <= nf_d;
            nstg_q  <= nstg_d;
            stage_q <= stage_d;
            dft_q   <= dft_d;
            state_q <= state_d;
            errf_q  <= errf_d;
            errt_q  <= errt_d;
            ovr_q   <= ovr_d;
        end
    end

    // Next-state logic.
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            S_SINK: if (seen_q && ok_q && (fell_q || fall) && !sink_sop) fsm_d = S_RD;
            S_RD:   if (fall) fsm_d = S_WR;
            S_WR: begin
                if (fall)       fsm_d = (stage_q == nstg_q - 3'd1) ? S_SRC : S_RD;
                else if (wr_to) fsm_d = S_SINK;
            end
            S_SRC:  fsm_d = S_SRCW;
            S_SRCW: if (fall) fsm_d = S_SINK;
            default: fsm_d = S_SINK;
        endcase
    end

    // Output and datapath next values.
    always_comb begin
        entering = (fsm_d != fsm_q);
        prev_d   = entering ? 1'b0 : watch;
        cnt_d    = entering ? '0 : ((fsm_q == S_WR) ? cnt_q + 1'b1 : cnt_q);

        fell_d = fell_q;
        if (entering || (fsm_q == S_SINK && sink_sop)) fell_d = 1'b0;
        else if (fsm_q == S_SINK && fall)             fell_d = 1'b1;

        stage_d = stage_q;
        if (fsm_q == S_WR && fsm_d == S_RD) stage_d = stage_q + 3'd1;
        else if (fsm_d == S_SINK)           stage_d = 3'd0;

        dft_d  = dft_q;
        r_d    = r_q;
        busy_d = busy_q;
        ok_d   = ok_q;
        nf_d   = nf_q;
        nstg_d = nstg_q;
        seen_d = seen_q;
        errf_d = 1'b0;

        // A SOP in SINK always restarts capture, even mid-factoring.
        if (fsm_q == S_SINK && sink_sop) begin
            dft_d  = sink_dftpts;
            r_d    = sink_dftpts;
            nf_d   = '0;
            nstg_d = 3'd0;
            ok_d   = 1'b0;
            seen_d = 1'b1;
            if (sink_dftpts < 12'd2) begin
                busy_d = 1'b0;
                errf_d = 1'b1;
            end else begin
                busy_d = 1'b1;
            end
        end else if (step_fail) begin
            busy_d = 1'b0;
            errf_d = 1'b1;
        end else if (fdone) begin
            busy_d = 1'b0;
            ok_d   = 1'b1;
        end else if (step_ok) begin
            r_d    = r_div;
            nstg_d = nstg_q + 3'd1;
            for (int k = 0; k < MAX_STAGES; k++)
                if (3'(k) == nstg_q) nf_d[3*k +: 3] = fac;
        end

        // A new SOP is required before the next frame can start.
        if (fsm_q == S_SINK && fsm_d != S_SINK) seen_d = 1'b0;

        state_d = enc(fsm_d);
        errt_d  = wr_to;
        ovr_d   = sink_sop && (fsm_q != S_SINK);
    end

    assign state         = state_q;
    assign dftpts        = dft_q;
    assign current_stage = stage_q;
    assign Nf            = nf_q;
    assign num_stages    = nstg_q;
    assign err_factor    = errf_q;
    assign err_timeout   = errt_q;
    assign overrun       = ovr_q;

endmodule
